// File: rtl/fifo16_read_unloader.sv
// fifo16_read_unloader
// ---------------------------------------------------------------------------
// Read-side unloader for a FIFO16 primitive used in standard (registered
// output, non first-word-fall-through) mode. Everything runs on the FIFO
// read clock.
//
// The block issues FIFO_RDEN whenever the FIFO is not empty and there is
// room for the word in a 4-entry skid buffer. Room means buffered words
// plus reads still in flight. Each returned word is captured READ_LATENCY
// cycles after its read was sampled, parity-checked per byte and pushed into
// the buffer. The buffer head is presented on a valid/ready stream.
//
// Parameters:
//   READ_LATENCY  cycles from a sampled FIFO_RDEN to valid FIFO_DO/DOP (1 or 2)
//   PARITY_CHECK  1 = even parity per byte checked, 0 = PAR_ERR held low
//   COUNT_WIDTH   width of the delivered-word counter
//
// Ports:
//   CLK            read clock (same net as FIFO16 RDCLK)
//   RST            synchronous active-high reset
//   FIFO_DO        FIFO16 data out
//   FIFO_DOP       FIFO16 parity out
//   FIFO_EMPTY     FIFO16 empty flag
//   FIFO_RDERR     FIFO16 read error (underflow) flag
//   FIFO_RDEN      read enable to the FIFO16
//   M_DATA         stream data (buffer head)
//   M_PAR          stream parity bits (buffer head)
//   M_VALID        buffer head is valid
//   M_READY        consumer accepts when M_VALID && M_READY
//   PAR_ERR        sticky parity mismatch flag
//   UNDERFLOW_ERR  sticky flag, set when a captured word carried RDERR
//   WORD_COUNT     number of stream handshakes, wraps naturally
// ---------------------------------------------------------------------------
module fifo16_read_unloader #(
    parameter int READ_LATENCY = 1,
    parameter int PARITY_CHECK = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            FIFO_DO,
    input  logic [3:0]             FIFO_DOP,
    input  logic                   FIFO_EMPTY,
    input  logic                   FIFO_RDERR,
    output logic                   FIFO_RDEN,
    output logic [31:0]            M_DATA,
    output logic [3:0]             M_PAR,
    output logic                   M_VALID,
    input  logic                   M_READY,
    output logic                   PAR_ERR,
    output logic                   UNDERFLOW_ERR,
    output logic [COUNT_WIDTH-1:0] WORD_COUNT
);

    localparam int DEPTH = 4;

    // One valid bit per outstanding read. A read enters at bit 0 and its
    // data is on FIFO_DO when it reaches the tail bit.
    logic [READ_LATENCY-1:0] pipe;
    logic [1:0]              inflight;
    logic                    tail;

    // Skid buffer: data and parity kept together as {DOP, DO}.
    logic [35:0] storage [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic        push;
    logic        pop;
    logic        drop;
    logic [3:0]  expected_par;
    logic        par_mismatch;
    logic [3:0]  credit_used;

    logic        par_err_q;
    logic        underflow_q;
    logic [COUNT_WIDTH-1:0] word_count_q;

    // Count of reads that have been issued but whose data has not yet been
    // captured. At most two for the supported latencies.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + 2'(pipe[i]);
        end
    end

    assign tail = pipe[READ_LATENCY-1];

    // Credit check: every issued read already owns a buffer slot, so the
    // buffer can never overflow. A pop happening in the same cycle is not
    // counted as free space; this keeps the issue path short and a
    // two-cycle pipe still fits within four slots at full rate.
    assign credit_used = {1'b0, count} + {2'b00, inflight};
    assign FIFO_RDEN   = !RST && !FIFO_EMPTY && (credit_used < 4'(DEPTH));

    // Even parity per byte: the DOP bit equals the XOR of its byte.
    always_comb begin
        expected_par = '0;
        for (int b = 0; b < 4; b++) begin
            expected_par[b] = ^FIFO_DO[8*b +: 8];
        end
    end

    assign par_mismatch = (PARITY_CHECK != 0) && (expected_par != FIFO_DOP);

    // A word that comes back flagged with RDERR is garbage from an empty
    // FIFO, so it is dropped rather than buffered.
    assign push = tail && !FIFO_RDERR;
    assign drop = tail &&  FIFO_RDERR;
    assign pop  = M_VALID && M_READY;

    // In-flight pipe. Clearing it on reset discards any read still on its
    // way back, so that data is never written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe[i] <= pipe[i-1];
            end
            pipe[0] <= FIFO_RDEN;
        end
    end

    // Buffer storage and pointers. Words are stored unmodified even when
    // their parity is wrong; the error is reported through PAR_ERR only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (push) begin
                storage[wr_ptr] <= {FIFO_DOP, FIFO_DO};
                wr_ptr          <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
        end
    end

    // Occupancy. A simultaneous push and pop leaves it unchanged; a pop
    // needs count >= 1, so the pushed slot is never the one being read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags and the delivered-word counter. The flags are
    // cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_err_q    <= 1'b0;
            underflow_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            if (push && par_mismatch) begin
                par_err_q <= 1'b1;
            end
            if (drop) begin
                underflow_q <= 1'b1;
            end
            if (pop) begin
                word_count_q <= word_count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // The head entry is read straight from registers, so it holds steady
    // while the consumer stalls.
    assign M_VALID       = (count != 3'd0);
    assign {M_PAR, M_DATA} = storage[rd_ptr];
    assign PAR_ERR       = par_err_q;
    assign UNDERFLOW_ERR = underflow_q;
    assign WORD_COUNT    = word_count_q;

    // The credit check must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(push && (count == 3'(DEPTH)) && !pop));

endmodule
